// File: rtl/ldpc_sched_pkg.sv
// Shared types and constants for the LDPC iteration scheduler.
package ldpc_sched_pkg;

  localparam int unsigned DRAIN_BITS = 4;

  typedef enum logic [3:0] {
    StIdle,
    StCnInit,
    StCnRun,
    StCnDrain,
    StVnInit,
    StVnRun,
    StVnDrain,
    StCheck,
    StDone
  } sched_state_t;

endpackage

// File: rtl/ldpc_decode_scheduler.sv
// LDPC iteration sequencer: alternates CN/VN address sweeps, drains the update
// pipeline, checks the syndrome and stops on convergence or the iteration limit.
module ldpc_decode_scheduler
  import ldpc_sched_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 8,
  parameter int unsigned CN_COUNT  = 4,
  parameter int unsigned VN_COUNT  = 6,
  parameter int unsigned PIPE_LAT  = 2,
  parameter int unsigned MAX_ITER  = 10,
  parameter int unsigned ITER_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 syndrome_ok,
  input  logic [NUM_BITS-1:0]  cn_addr,
  input  logic [NUM_BITS-1:0]  vn_addr,
  output logic                 cn_ag_enable,
  output logic                 cn_ag_reset,
  output logic                 vn_ag_enable,
  output logic                 vn_ag_reset,
  output logic                 cn_active,
  output logic                 vn_active,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic [ITER_BITS-1:0] iter_count
);

  localparam logic [NUM_BITS-1:0]   CnLast    = NUM_BITS'(CN_COUNT - 1);
  localparam logic [NUM_BITS-1:0]   VnLast    = NUM_BITS'(VN_COUNT - 1);
  localparam logic [DRAIN_BITS-1:0] DrainLast = DRAIN_BITS'((PIPE_LAT == 0) ? 0 : PIPE_LAT - 1);
  localparam logic [ITER_BITS-1:0]  IterMax   = ITER_BITS'(MAX_ITER);
  localparam bit                    NoDrain   = (PIPE_LAT == 0);

  sched_state_t          state_q, state_d;
  logic [DRAIN_BITS-1:0] drain_q;
  logic [ITER_BITS-1:0]  iter_q;
  logic                  conv_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCnInit;
      StCnInit:  state_d = StCnRun;
      StCnRun:   if (cn_addr == CnLast) state_d = NoDrain ? StVnInit : StCnDrain;
      StCnDrain: if (drain_q == DrainLast) state_d = StVnInit;
      StVnInit:  state_d = StVnRun;
      StVnRun:   if (vn_addr == VnLast) state_d = NoDrain ? StCheck : StVnDrain;
      StVnDrain: if (drain_q == DrainLast) state_d = StCheck;
      StCheck: begin
        if (syndrome_ok || iter_q == IterMax) state_d = StDone;
        else                                  state_d = StCnInit;
      end
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (abort && state_q != StIdle) state_d = StIdle;
  end

  // Drain counter only runs while parked in a drain state; any exit clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      drain_q <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
    end else begin
      if ((state_q == StCnDrain || state_q == StVnDrain) && state_d == state_q) begin
        drain_q <= drain_q + 1'b1;
      end else begin
        drain_q <= '0;
      end
      if (state_q == StIdle && start) begin
        iter_q <= '0;
        conv_q <= 1'b0;
      end
      if (state_d == StCheck && state_q != StCheck) iter_q <= iter_q + 1'b1;
      if (state_q == StCheck && state_d == StDone) conv_q <= syndrome_ok;
    end
  end

  always_comb begin
    cn_ag_enable = 1'b0;
    cn_ag_reset  = 1'b0;
    vn_ag_enable = 1'b0;
    vn_ag_reset  = 1'b0;
    cn_active    = 1'b0;
    vn_active    = 1'b0;
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    unique case (state_q)
      StCnInit: begin
        cn_ag_enable = 1'b1;
        cn_ag_reset  = 1'b1;
      end
      StCnRun: begin
        cn_active    = 1'b1;
        cn_ag_enable = (cn_addr != CnLast);
      end
      StVnInit: begin
        vn_ag_enable = 1'b1;
        vn_ag_reset  = 1'b1;
      end
      StVnRun: begin
        vn_active    = 1'b1;
        vn_ag_enable = (vn_addr != VnLast);
      end
      default: ;
    endcase
  end

  assign converged  = conv_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_ldpc_decode_scheduler.sv
// Directed bench for ldpc_decode_scheduler: three parameterisations share stimulus,
// each with a behavioural model of its external address-generator counters.
module tb_ldpc_decode_scheduler;
  import ldpc_sched_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, syndrome_ok = 1'b0;
  int   n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  logic [7:0] cn_addr_a = '0, vn_addr_a = '0, cn_addr_b = '0, vn_addr_b = '0;
  logic [7:0] cn_addr_c = '0, vn_addr_c = '0;
  logic cn_en_a, cn_rst_a, vn_en_a, vn_rst_a, cn_act_a, vn_act_a, busy_a, done_a, conv_a;
  logic cn_en_b, cn_rst_b, vn_en_b, vn_rst_b, cn_act_b, vn_act_b, busy_b, done_b, conv_b;
  logic cn_en_c, cn_rst_c, vn_en_c, vn_rst_c, cn_act_c, vn_act_c, busy_c, done_c, conv_c;
  logic [3:0] iter_a, iter_b, iter_c;

  ldpc_decode_scheduler dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .syndrome_ok(syndrome_ok),
    .cn_addr(cn_addr_a), .vn_addr(vn_addr_a), .cn_ag_enable(cn_en_a), .cn_ag_reset(cn_rst_a),
    .vn_ag_enable(vn_en_a), .vn_ag_reset(vn_rst_a), .cn_active(cn_act_a), .vn_active(vn_act_a),
    .busy(busy_a), .done(done_a), .converged(conv_a), .iter_count(iter_a)
  );

  ldpc_decode_scheduler #(.MAX_ITER(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .syndrome_ok(syndrome_ok),
    .cn_addr(cn_addr_b), .vn_addr(vn_addr_b), .cn_ag_enable(cn_en_b), .cn_ag_reset(cn_rst_b),
    .vn_ag_enable(vn_en_b), .vn_ag_reset(vn_rst_b), .cn_active(cn_act_b), .vn_active(vn_act_b),
    .busy(busy_b), .done(done_b), .converged(conv_b), .iter_count(iter_b)
  );

  ldpc_decode_scheduler #(.PIPE_LAT(0), .CN_COUNT(1), .VN_COUNT(1), .MAX_ITER(2)) dut_c (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .syndrome_ok(syndrome_ok),
    .cn_addr(cn_addr_c), .vn_addr(vn_addr_c), .cn_ag_enable(cn_en_c), .cn_ag_reset(cn_rst_c),
    .vn_ag_enable(vn_en_c), .vn_ag_reset(vn_rst_c), .cn_active(cn_act_c), .vn_active(vn_act_c),
    .busy(busy_c), .done(done_c), .converged(conv_c), .iter_count(iter_c)
  );

  // Address-generator counters: clear on enable+reset, increment on enable alone.
  always_ff @(posedge clk) begin
    if (cn_en_a) cn_addr_a <= cn_rst_a ? 8'd0 : cn_addr_a + 8'd1;
    if (vn_en_a) vn_addr_a <= vn_rst_a ? 8'd0 : vn_addr_a + 8'd1;
    if (cn_en_b) cn_addr_b <= cn_rst_b ? 8'd0 : cn_addr_b + 8'd1;
    if (vn_en_b) vn_addr_b <= vn_rst_b ? 8'd0 : vn_addr_b + 8'd1;
    if (cn_en_c) cn_addr_c <= cn_rst_c ? 8'd0 : cn_addr_c + 8'd1;
    if (vn_en_c) vn_addr_c <= vn_rst_c ? 8'd0 : vn_addr_c + 8'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; syndrome_ok = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b1; syndrome_ok = 1'b1;
    tick(); tick();
    n_vec++;
    if (dut_a.state_q !== StIdle) begin
      n_bad++; $display("FAIL reset_state: got %0d expected %0d", dut_a.state_q, StIdle);
    end
    n_vec++;
    if ({cn_en_a, cn_rst_a, vn_en_a, vn_rst_a, cn_act_a, vn_act_a} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {cn_en_a, cn_rst_a, vn_en_a, vn_rst_a, cn_act_a, vn_act_a});
    end
    n_vec++;
    if ({busy_a, done_a, conv_a, iter_a} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_status: got %b expected 0000000", {busy_a, done_a, conv_a, iter_a});
    end
    start = 1'b0; abort = 1'b0; syndrome_ok = 1'b0; reset = 1'b0;
    tick();
    n_vec++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_bad++; $display("FAIL reset_release: got busy=%b done=%b expected 0 0", busy_a, done_a);
    end
  endtask

  task automatic test_converge();
    int cn_seq[$];
    int vn_seq[$];
    int done_at = 0;
    int edge_n;
    bit ok;
    syndrome_ok = 1'b1; start = 1'b1;
    tick(); start = 1'b0; edge_n = 1;
    while (done_at == 0 && edge_n < 60) begin
      if (cn_act_a) cn_seq.push_back(int'(cn_addr_a));
      if (vn_act_a) vn_seq.push_back(int'(vn_addr_a));
      if (done_a) done_at = edge_n + 1;
      else begin tick(); edge_n++; end
    end
    ok = (cn_seq.size() == 4);
    for (int i = 0; i < cn_seq.size(); i++) if (cn_seq[i] != i) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++; $display("FAIL conv_cn_seq: got %0d addresses %p expected 0..3", cn_seq.size(), cn_seq);
    end
    ok = (vn_seq.size() == 6);
    for (int i = 0; i < vn_seq.size(); i++) if (vn_seq[i] != i) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++; $display("FAIL conv_vn_seq: got %0d addresses %p expected 0..5", vn_seq.size(), vn_seq);
    end
    n_vec++;
    if (done_at != 19) begin
      n_bad++; $display("FAIL conv_done_cycle: got %0d expected 19", done_at);
    end
    n_vec++;
    if (conv_a !== 1'b1 || iter_a !== 4'd1) begin
      n_bad++; $display("FAIL conv_result: got conv=%b iter=%0d expected 1 1", conv_a, iter_a);
    end
    syndrome_ok = 1'b0;
    tick();
    n_vec++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || conv_a !== 1'b1) begin
      n_bad++;
      $display("FAIL conv_after_done: got done=%b busy=%b conv=%b expected 0 0 1",
               done_a, busy_a, conv_a);
    end
  endtask

  task automatic test_max_iter();
    int done_at = 0;
    int edge_n;
    int clears = 0;
    syndrome_ok = 1'b0; start = 1'b1;
    tick(); start = 1'b0; edge_n = 1;
    while (done_at == 0 && edge_n < 120) begin
      if (cn_en_b && cn_rst_b) clears++;
      if (done_b) done_at = edge_n + 1;
      else begin tick(); edge_n++; end
    end
    n_vec++;
    if (done_at != 53) begin
      n_bad++; $display("FAIL maxit_done_cycle: got %0d expected 53", done_at);
    end
    n_vec++;
    if (conv_b !== 1'b0 || iter_b !== 4'd3) begin
      n_bad++; $display("FAIL maxit_result: got conv=%b iter=%0d expected 0 3", conv_b, iter_b);
    end
    n_vec++;
    if (clears != 3) begin
      n_bad++; $display("FAIL maxit_cn_clears: got %0d expected 3", clears);
    end
    tick();
  endtask

  task automatic test_no_drain();
    int cn_edges[$];
    int vn_edges[$];
    int done_edge = 0;
    int edge_n;
    int quiet = 0;
    syndrome_ok = 1'b0; start = 1'b1;
    tick(); start = 1'b0; edge_n = 1;
    while (done_edge == 0 && edge_n < 40) begin
      if (cn_act_c) cn_edges.push_back(edge_n);
      if (vn_act_c) vn_edges.push_back(edge_n);
      // Busy with no control activity and no done is only CHECK when drain is disabled.
      if (busy_c && !done_c &&
          {cn_en_c, cn_rst_c, vn_en_c, vn_rst_c, cn_act_c, vn_act_c} == 6'b0) quiet++;
      if (done_c) done_edge = edge_n;
      else begin tick(); edge_n++; end
    end
    n_vec++;
    if (cn_edges.size() != 2 || cn_edges[0] != 2 || cn_edges[1] != 7) begin
      n_bad++; $display("FAIL nodrain_cn_active: got %p expected '{2, 7}", cn_edges);
    end
    n_vec++;
    if (vn_edges.size() != 2 || vn_edges[0] != 4 || vn_edges[1] != 9) begin
      n_bad++; $display("FAIL nodrain_vn_active: got %p expected '{4, 9}", vn_edges);
    end
    n_vec++;
    if (done_edge != 11 || quiet != 2) begin
      n_bad++; $display("FAIL nodrain_timing: got done_edge=%0d quiet=%0d expected 11 2",
                        done_edge, quiet);
    end
    tick();
  endtask

  task automatic test_abort();
    int wait_n = 0;
    int dones = 0;
    syndrome_ok = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    while (!(vn_act_a && vn_addr_a == 8'd3) && wait_n < 40) begin
      tick(); wait_n++;
    end
    n_vec++;
    if (!(vn_act_a && vn_addr_a == 8'd3)) begin
      n_bad++; $display("FAIL abort_reach_vn3: got vn_active=%b vn_addr=%0d expected 1 3",
                        vn_act_a, vn_addr_a);
    end
    abort = 1'b1;
    tick(); abort = 1'b0;
    n_vec++;
    if (busy_a !== 1'b0 || dut_a.state_q !== StIdle) begin
      n_bad++; $display("FAIL abort_idle: got busy=%b state=%0d expected 0 %0d",
                        busy_a, dut_a.state_q, StIdle);
    end
    n_vec++;
    if (iter_a !== 4'd0 || conv_a !== 1'b0) begin
      n_bad++; $display("FAIL abort_hold: got iter=%0d conv=%b expected 0 0", iter_a, conv_a);
    end
    for (int i = 0; i < 20; i++) begin
      if (done_a || busy_a) dones++;
      tick();
    end
    n_vec++;
    if (dones != 0) begin
      n_bad++; $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    int done_at = 0;
    int edge_n;
    syndrome_ok = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick(); start = 1'b1;
    tick(); start = 1'b0; edge_n = 3;
    while (done_at == 0 && edge_n < 60) begin
      if (done_a) done_at = edge_n + 1;
      else begin tick(); edge_n++; end
    end
    n_vec++;
    if (done_at != 19 || iter_a !== 4'd1 || conv_a !== 1'b1) begin
      n_bad++; $display("FAIL b2b_start_in_run: got done=%0d iter=%0d conv=%b expected 19 1 1",
                        done_at, iter_a, conv_a);
    end
    start = 1'b1;
    tick();
    n_vec++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_bad++; $display("FAIL b2b_start_in_done: got busy=%b done=%b expected 0 0", busy_a, done_a);
    end
    tick(); start = 1'b0;
    n_vec++;
    if (busy_a !== 1'b1 || cn_rst_a !== 1'b1 || iter_a !== 4'd0 || conv_a !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_relaunch: got busy=%b cn_rst=%b iter=%0d conv=%b expected 1 1 0 0",
               busy_a, cn_rst_a, iter_a, conv_a);
    end
  endtask

  initial begin
    test_reset();
    test_converge();
    do_reset();
    test_max_iter();
    do_reset();
    test_no_drain();
    do_reset();
    test_abort();
    do_reset();
    test_back_to_back();
    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
